// File: rtl/uf_op_scheduler.sv
// Purpose    : queue first-pass unions, arbitrate them (strict priority) against find requests,
//              and issue one union-find operation at a time with a start/done handshake.
// Latency    : union strobe -> uf_start 2 cycles; find handshake -> uf_start 1; uf_done -> find_res_vld 1.
// Backpressure: unions have none (dropped and flagged when the queue is full); finds wait on find_rdy.
//
// Optional build macro: UF_SCHED_DEDUP_EN -- drop a union whose (min,max) pair equals the last
// enqueued pair. Without it every filtered union is enqueued.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   frame_start                    flush queue, abort op, clear status, run an engine clear
//   union_vld/union_a/union_b      union requests (no back-pressure)
//   find_vld/find_label/find_rdy   find request handshake
//   find_res_vld/find_res_label    find result pulse (label 0 on timeout)
//   uf_clear/uf_start/uf_op        engine control (op 01 UNION, 10 FIND, 00 idle)
//   uf_node1/uf_node2              engine operands, held from ISSUE through WAIT
//   uf_done/uf_result/uf_idle      engine status
//   q_count/busy                   queue occupancy, activity
//   overflow/timeout_err           per-frame sticky status
module uf_op_scheduler #(
    parameter int ADDR_WIDTH = 8,
    parameter int QDEPTH     = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame_start,
    input  logic                    union_vld,
    input  logic [ADDR_WIDTH-1:0]   union_a,
    input  logic [ADDR_WIDTH-1:0]   union_b,
    input  logic                    find_vld,
    input  logic [ADDR_WIDTH-1:0]   find_label,
    output logic                    find_rdy,
    output logic                    find_res_vld,
    output logic [ADDR_WIDTH-1:0]   find_res_label,
    output logic                    uf_clear,
    output logic                    uf_start,
    output logic [1:0]              uf_op,
    output logic [ADDR_WIDTH-1:0]   uf_node1,
    output logic [ADDR_WIDTH-1:0]   uf_node2,
    input  logic                    uf_done,
    input  logic [ADDR_WIDTH-1:0]   uf_result,
    input  logic                    uf_idle,
    output logic [$clog2(QDEPTH):0] q_count,
    output logic                    busy,
    output logic                    overflow,
    output logic                    timeout_err
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_UNION = 2'b01;
    localparam logic [1:0] OP_FIND  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_ISSUE = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    // union queue: normalized pairs, lo in one array and hi in the other
    logic [ADDR_WIDTH-1:0] r_q_lo [QDEPTH];
    logic [ADDR_WIDTH-1:0] r_q_hi [QDEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;

    logic [TW-1:0]         r_wait_cnt;
    logic                  r_clr_seen;

    logic [1:0]            r_op;
    logic [ADDR_WIDTH-1:0] r_node1;
    logic [ADDR_WIDTH-1:0] r_node2;
    logic                  r_res_vld;
    logic [ADDR_WIDTH-1:0] r_res_label;
    logic                  r_overflow;
    logic                  r_timeout;

    logic [ADDR_WIDTH-1:0] w_lo;
    logic [ADDR_WIDTH-1:0] w_hi;
    logic                  w_filt;
    logic                  w_dup;
    logic                  w_want;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_push;
    logic                  w_ovf;
    logic                  w_pop;
    logic                  w_find_acc;
    logic                  w_find_rdy;
    logic                  w_op_done;
    logic                  w_op_tmo;

    //------------------------------------------------------------------
    // Union filter and queue control
    //------------------------------------------------------------------
    assign w_lo   = (union_a < union_b) ? union_a : union_b;
    assign w_hi   = (union_a < union_b) ? union_b : union_a;
    // label 0 is background and a self-union is a no-op; a union coincident with
    // frame_start belongs to the frame being discarded
    assign w_filt = union_vld & ~frame_start & (union_a != '0) & (union_b != '0)
                  & (union_a != union_b);

`ifdef UF_SCHED_DEDUP_EN
    logic [ADDR_WIDTH-1:0] r_last_lo;
    logic [ADDR_WIDTH-1:0] r_last_hi;

    // last pair resets to (0,0), which no filtered union can match
    assign w_dup = (w_lo == r_last_lo) & (w_hi == r_last_hi);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_lo <= '0;
            r_last_hi <= '0;
        end else if (frame_start) begin
            r_last_lo <= '0;
            r_last_hi <= '0;
        end else if (w_push) begin
            r_last_lo <= w_lo;
            r_last_hi <= w_hi;
        end
    end
`else
    assign w_dup = 1'b0;
`endif

    assign w_want  = w_filt & ~w_dup;
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(QDEPTH));
    // a full queue still takes a push when the head leaves in the same cycle
    assign w_push  = w_want & (~w_full | w_pop);
    assign w_ovf   = w_want & ~w_push;

    assign w_find_rdy = (r_state == S_IDLE) & w_empty & uf_idle & ~frame_start & ~union_vld;

    //------------------------------------------------------------------
    // FSM next state
    //------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_find_acc  = 1'b0;
        w_op_done   = 1'b0;
        w_op_tmo    = 1'b0;
        if (frame_start) begin
            w_state_nxt = S_CLEAR;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty && uf_idle) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_ISSUE;
                    end else if (find_vld && w_find_rdy) begin
                        w_find_acc  = 1'b1;
                        w_state_nxt = S_ISSUE;
                    end
                end
                S_CLEAR: begin
                    // r_clr_seen guarantees a second CLEAR cycle
                    if (r_clr_seen && uf_idle) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_ISSUE: begin
                    w_state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    // done wins over a coincident timeout
                    if (uf_done) begin
                        w_op_done   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else if (r_wait_cnt == TW'(TIMEOUT)) begin
                        w_op_tmo    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    //------------------------------------------------------------------
    // Sequential state
    //------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_clr_seen <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= (frame_start || r_state != S_WAIT) ? '0 : r_wait_cnt + TW'(1);
            r_clr_seen <= ~frame_start & (r_state == S_CLEAR);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (frame_start) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // queue storage needs no reset: occupancy is tracked by r_count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_lo[r_wr_ptr] <= w_lo;
            r_q_hi[r_wr_ptr] <= w_hi;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= OP_NONE;
            r_node1 <= '0;
            r_node2 <= '0;
        end else if (frame_start) begin
            r_op    <= OP_NONE;
            r_node1 <= '0;
            r_node2 <= '0;
        end else if (w_pop) begin
            r_op    <= OP_UNION;
            r_node1 <= r_q_lo[r_rd_ptr];
            r_node2 <= r_q_hi[r_rd_ptr];
        end else if (w_find_acc) begin
            r_op    <= OP_FIND;
            r_node1 <= find_label;
            r_node2 <= '0;
        end else if (w_op_done || w_op_tmo) begin
            r_op    <= OP_NONE;
            r_node1 <= '0;
            r_node2 <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_vld   <= 1'b0;
            r_res_label <= '0;
        end else begin
            r_res_vld <= 1'b0;
            if (r_op == OP_FIND) begin
                if (w_op_done) begin
                    r_res_vld   <= 1'b1;
                    r_res_label <= uf_result;
                end else if (w_op_tmo) begin
                    r_res_vld   <= 1'b1;
                    r_res_label <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
            r_timeout  <= 1'b0;
        end else if (frame_start) begin
            r_overflow <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_ovf) begin
                r_overflow <= 1'b1;
            end
            if (w_op_tmo) begin
                r_timeout <= 1'b1;
            end
        end
    end

    //------------------------------------------------------------------
    // Outputs
    //------------------------------------------------------------------
    assign find_rdy       = w_find_rdy;
    assign find_res_vld   = r_res_vld;
    assign find_res_label = r_res_label;
    assign uf_clear       = (r_state == S_CLEAR) & ~r_clr_seen;
    assign uf_start       = (r_state == S_ISSUE);
    assign uf_op          = r_op;
    assign uf_node1       = r_node1;
    assign uf_node2       = r_node2;
    assign q_count        = r_count;
    assign busy           = (r_state != S_IDLE) | ~w_empty;
    assign overflow       = r_overflow;
    assign timeout_err    = r_timeout;

endmodule
